hash160_ripemd_feeder: RTL and testbench

Upstream feeder for `ripemd_final` in the Hash160 datapath. It accepts 256-bit SHA-256 digests over a valid/ready handshake and buffers them in a small FIFO. For each digest it builds the single padded 512-bit RIPEMD-160 block, launches one `ripemd_final` job, and waits for completion. The 160-bit result is presented on a registered valid/ready output, and a watchdog guards against a hung core.

---
 rtl/hash160_pkg.sv | 25 ++
 rtl/hash160_fifo.sv | 64 ++++++
 rtl/hash160_ripemd_feeder.sv | 130 +++++++++++++
 tb/tb_hash160_ripemd_feeder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash160_pkg.sv
// Shared definitions for the Hash160 RIPEMD-160 stage: widths, padding tail,
// feeder FSM states and the single-block padding helper.
package hash160_pkg;

    localparam int SHA_DIGEST_W = 256;
    localparam int RMD_BLOCK_W  = 512;
    localparam int RMD_DIGEST_W = 160;

    // 0x80 terminator, zero fill, then 256 as a little-endian 64-bit length
    localparam logic [RMD_BLOCK_W-SHA_DIGEST_W-1:0] RMD_PAD_TAIL =
        {8'h80, 184'h0, 64'h0001_0000_0000_0000};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } feeder_state_e;

    function automatic logic [RMD_BLOCK_W-1:0] rmd_pad_256(
        input logic [SHA_DIGEST_W-1:0] digest
    );
        return {digest, RMD_PAD_TAIL};
    endfunction

endpackage

// File: rtl/hash160_fifo.sv
// Synchronous FIFO with a registered occupancy count; full/empty come from
// the count so both are glitch-free register decodes.
module hash160_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/hash160_ripemd_feeder.sv
// Buffers SHA-256 digests, pads each into one RIPEMD-160 block, runs one
// ripemd_final job per digest and holds the result on a valid/ready output.
//
//   state  | meaning
//   IDLE   | waiting for a queued digest and an empty output register
//   LAUNCH | core_i_valid high for this single cycle, watchdog cleared
//   WAIT   | waiting for core_o_valid or the watchdog limit
module hash160_ripemd_feeder
    import hash160_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SHA_DIGEST_W-1:0] in_digest,
    output logic                    core_i_valid,
    output logic [RMD_BLOCK_W-1:0]  core_block,
    input  logic [RMD_DIGEST_W-1:0] core_ans,
    input  logic                    core_o_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RMD_DIGEST_W-1:0] out_hash,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int              WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT);

    feeder_state_e             state_q, state_d;
    logic                      core_i_valid_q, core_i_valid_d;
    logic [RMD_BLOCK_W-1:0]    core_block_q, core_block_d;
    logic                      out_valid_q, out_valid_d;
    logic [RMD_DIGEST_W-1:0]   out_hash_q, out_hash_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [WDW-1:0]            wd_cnt_q, wd_cnt_d;
    logic [WDW-1:0]            wd_next;
    logic                      job_pop;
    logic                      fifo_full, fifo_empty;
    logic [SHA_DIGEST_W-1:0]   fifo_rdata;

    hash160_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SHA_DIGEST_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (job_pop),
        .wdata (in_digest),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        core_i_valid_d = 1'b0;
        core_block_d   = core_block_q;
        out_valid_d    = out_valid_q;
        out_hash_d     = out_hash_q;
        timeout_err_d  = timeout_err_q;
        wd_cnt_d       = wd_cnt_q;
        job_pop        = 1'b0;
        wd_next        = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + WDW'(1);

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Launch only into an empty output register so no result is lost
                if (!fifo_empty && !out_valid_q) begin
                    state_d        = ST_LAUNCH;
                    core_i_valid_d = 1'b1;
                    core_block_d   = rmd_pad_256(fifo_rdata);
                end
            end
            ST_LAUNCH: begin
                state_d  = ST_WAIT;
                wd_cnt_d = '0;
            end
            ST_WAIT: begin
                wd_cnt_d = wd_next;
                if (core_o_valid) begin
                    out_hash_d  = core_ans;
                    out_valid_d = 1'b1;
                    job_pop     = 1'b1;
                    state_d     = ST_IDLE;
                end else if (wd_next == WD_LIMIT) begin
                    timeout_err_d = 1'b1;
                    job_pop       = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            core_i_valid_q <= 1'b0;
            core_block_q   <= '0;
            out_valid_q    <= 1'b0;
            out_hash_q     <= '0;
            timeout_err_q  <= 1'b0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            core_i_valid_q <= core_i_valid_d;
            core_block_q   <= core_block_d;
            out_valid_q    <= out_valid_d;
            out_hash_q     <= out_hash_d;
            timeout_err_q  <= timeout_err_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    assign in_ready     = !fifo_full;
    assign core_i_valid = core_i_valid_q;
    assign core_block   = core_block_q;
    assign out_valid    = out_valid_q;
    assign out_hash     = out_hash_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hash160_ripemd_feeder.sv
// Bench for hash160_ripemd_feeder: behavioural ripemd_final stand-in with
// programmable latency, digest/result scoreboards and directed timing checks.
module tb_hash160_ripemd_feeder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_digest;
    logic         core_i_valid;
    logic [511:0] core_block;
    logic [159:0] core_ans;
    logic         core_o_valid;
    logic         out_valid;
    logic         out_ready;
    logic [159:0] out_hash;
    logic         busy;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;
    int n_recv = 0;
    int core_lat = 5;
    bit core_hang = 1'b0;
    int spur_cnt = 0;
    logic [159:0] last_exp = '0;

    logic [255:0] exp_dig [$];
    logic [159:0] exp_hash [$];

    always #5 clk = ~clk;

    hash160_ripemd_feeder #(
        .DEPTH   (2),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_digest    (in_digest),
        .core_i_valid (core_i_valid),
        .core_block   (core_block),
        .core_ans     (core_ans),
        .core_o_valid (core_o_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hash     (out_hash),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] ans_of(input logic [255:0] x);
        return x[255:96] ^ {x[63:0], x[255:160]};
    endfunction

    function automatic logic [255:0] rand_dig();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [511:0] pad_of(input logic [255:0] d);
        return {d, 8'h80, 184'h0, 64'h0001_0000_0000_0000};
    endfunction

    // Behavioural ripemd_final: one job at a time, answer after core_lat cycles
    initial begin
        logic [511:0] blk;
        logic [255:0] d;
        int spur_seen;
        spur_seen    = 0;
        core_o_valid = 1'b0;
        core_ans     = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) continue;
            if (spur_cnt != spur_seen) begin
                spur_seen    = spur_cnt;
                core_o_valid = 1'b1;
                core_ans     = rand_dig()[159:0];
                @(posedge clk); #1;
                core_o_valid = 1'b0;
            end else if (core_i_valid) begin
                blk = core_block;
                d   = '0;
                if (exp_dig.size() == 0) begin
                    chk("launch_unexpected", 512'(core_i_valid), '0);
                end else begin
                    d = exp_dig.pop_front();
                    chk("core_block", blk, pad_of(d));
                end
                @(posedge clk); #1;
                chk("i_valid_pulse", 512'(core_i_valid), '0);
                if (!core_hang) begin
                    repeat (core_lat - 1) begin @(posedge clk); #1; end
                    core_o_valid = 1'b1;
                    core_ans     = ans_of(blk[511:256]);
                    exp_hash.push_back(ans_of(d));
                    @(posedge clk); #1;
                    core_o_valid = 1'b0;
                    chk("out_valid_rise", 512'(out_valid), 512'(1));
                    chk("core_block_stable", core_block, blk);
                end
            end
        end
    end

    // Output scoreboard: compare every accepted result in push order
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_hash.size() == 0) begin
                    chk("out_unexpected", 512'(out_valid), '0);
                end else begin
                    last_exp = exp_hash.pop_front();
                    chk("out_hash", 512'(out_hash), 512'(last_exp));
                end
                n_recv++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench stuck");
    end

    task automatic push_dig(input logic [255:0] d);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_digest = d;
        for (int g = 0; g < 300 && !done; g++) begin
            if (in_ready) begin
                exp_dig.push_back(d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_accept", 512'(in_ready), 512'(1));
    endtask

    task automatic wait_recv(input int n);
        for (int g = 0; g < 3000 && n_recv < n; g++) begin
            @(posedge clk); #1;
        end
        chk("recv_count", 512'(n_recv), 512'(n));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},     512'(in_ready),     512'(1));
        chk({tag, "_core_i_valid"}, 512'(core_i_valid), '0);
        chk({tag, "_core_block"},   core_block,         '0);
        chk({tag, "_out_valid"},    512'(out_valid),    '0);
        chk({tag, "_out_hash"},     512'(out_hash),     '0);
        chk({tag, "_busy"},         512'(busy),         '0);
        chk({tag, "_timeout_err"},  512'(timeout_err),  '0);
    endtask

    initial begin
        int n;
        int target;
        logic [255:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_digest = '0;
        out_ready = 1'b1;
        idle_cycles(3);
        chk_reset_values("rst");
        rst_n = 1'b1;
        idle_cycles(2);

        // All-zero digest: launch two cycles after push, padded block checked by core model
        core_lat = 12;
        push_dig('0);
        chk("lat_t1_no_launch", 512'(core_i_valid), '0);
        chk("lat_t1_busy", 512'(busy), 512'(1));
        @(posedge clk); #1;
        chk("lat_t2_launch", 512'(core_i_valid), 512'(1));
        wait_recv(1);

        // Back-pressure: one held result plus two queued, then in_ready drops
        core_lat  = 4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_dig(rand_dig());
        idle_cycles(20);
        chk("bp_in_ready_low", 512'(in_ready), '0);
        chk("bp_out_held", 512'(out_valid), 512'(1));
        chk("bp_busy", 512'(busy), 512'(1));
        out_ready = 1'b1;
        push_dig(rand_dig());
        wait_recv(5);

        // One bubble between consuming a result and the next launch
        out_ready = 1'b0;
        push_dig(rand_dig());
        push_dig(rand_dig());
        for (int g = 0; g < 100 && !out_valid; g++) begin @(posedge clk); #1; end
        chk("bubble_held", 512'(out_valid), 512'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bubble_c1", 512'(core_i_valid), '0);
        @(posedge clk); #1;
        chk("bubble_c2", 512'(core_i_valid), 512'(1));
        wait_recv(7);

        // Boundary: answer in the last WAIT cycle still completes
        core_lat = 15;
        push_dig(rand_dig());
        wait_recv(8);
        chk("lat15_no_timeout", 512'(timeout_err), '0);

        // Hung core: watchdog fires 16 cycles after launch, entry dropped
        core_hang = 1'b1;
        push_dig(rand_dig());
        for (int g = 0; g < 50 && !core_i_valid; g++) begin @(posedge clk); #1; end
        n = 0;
        for (int g = 0; g < 100 && !timeout_err; g++) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_latency", 512'(n), 512'(16));
        chk("timeout_no_out", 512'(out_valid), '0);
        chk("timeout_idle", 512'(busy), '0);
        core_hang = 1'b0;
        core_lat  = 3;
        push_dig(rand_dig());
        wait_recv(9);
        chk("timeout_sticky", 512'(timeout_err), 512'(1));

        // Spurious core_o_valid while idle is ignored
        spur_cnt++;
        idle_cycles(6);
        chk("spur_out_valid", 512'(out_valid), '0);
        chk("spur_out_hash", 512'(out_hash), 512'(last_exp));

        // Reset during WAIT with the FIFO full discards everything
        core_hang = 1'b1;
        push_dig(rand_dig());
        push_dig(rand_dig());
        idle_cycles(5);
        chk("pre_rst_busy", 512'(busy), 512'(1));
        chk("pre_rst_in_ready", 512'(in_ready), '0);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        exp_dig.delete();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        core_hang = 1'b0;
        idle_cycles(2);
        chk_reset_values("postrst");
        push_dig(rand_dig());
        wait_recv(10);

        // Randomised traffic: random gaps, latencies and consumer stalls
        target = 40;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    idle_cycles($urandom_range(0, 3));
                    core_lat = $urandom_range(1, 15);
                    d = rand_dig();
                    push_dig(d);
                end
            end
            begin
                for (int k = 0; k < 4000 && n_recv < target; k++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_recv(target);
        idle_cycles(5);
        chk("end_dig_queue", 512'(exp_dig.size()), '0);
        chk("end_hash_queue", 512'(exp_hash.size()), '0);
        chk("end_idle", 512'(busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
